vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA timing generator for the Go Board video path. It replaces the fixed 640x480 sync generator and produces horizontal/vertical sync, an active-area flag and pixel coordinates for any resolution set by parameters. It also adds line-start and frame-start strobes and programmable sync polarity. It sits between the 25 MHz board clock and the pattern/pixel generators that consume o_px/o_py.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of o_hs (0 = active-low)
- VS_POL, 0, asserted level of o_vs (0 = active-low)
- COORD_W, 10, coordinate width; both H_TOTAL and V_TOTAL must be ≤ 2^COORD_W
- SYNC_DELAY, 2, strobe/sync delay in cycles; used only with VGA_TIMING_DELAY_EN
- i_clk  in  1  pixel clock
- i_reset  in  1  synchronous active-high reset; one clock, no clock enable
- o_hs  out  1  horizontal sync, polarity HS_POL
- o_vs  out  1  vertical sync, polarity VS_POL
- o_activeArea  out  1  high while px < H_ACTIVE and py < V_ACTIVE
- o_px  out  COORD_W  pixel column, 0..H_TOTAL-1
- o_py  out  COORD_W  line number, 0..V_TOTAL-1
- o_lineStart  out  1  one-cycle pulse at px = 0 on every line
- o_frameStart  out  1  one-cycle pulse at (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL is formed the same way (default 525).
- Line layout: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. The vertical layout is analogous in lines.
- px increments every cycle. At px = H_TOTAL-1, px wraps to 0 and py increments. At py = V_TOTAL-1 together with px wrap, py wraps to 0.
- Internal position resets to (H_TOTAL-1, V_TOTAL-1), so the first non-reset edge advances to (0,0).
- vs is asserted for whole lines: the full H_TOTAL cycles of each sync line.
- All outputs are registered and mutually aligned: in any cycle, hs/vs/activeArea/strobes decode the o_px/o_py shown in that cycle.
- Reset values: o_px=0, o_py=0, o_activeArea=0, o_lineStart=0, o_frameStart=0, o_hs=!HS_POL, o_vs=!VS_POL.
- Reset mid-frame: takes effect on the next edge. Every output takes its reset value regardless of position. No partial line is resumed.

## Timing
- Counter-to-output latency is 0 cycles; all outputs are updated by the same edge.
- The first edge with i_reset=0 after reset gives px=0, py=0, activeArea=1, lineStart=1, frameStart=1.
- Default periods: line is 800 cycles, frame is 420 000 cycles (16.8 ms at 25 MHz).
- Strobes are high for exactly one cycle and never overlap reset.

## Configuration
- VGA_TIMING_DELAY_EN defined:
  - o_hs, o_vs, o_activeArea, o_lineStart and o_frameStart pass through a SYNC_DELAY-stage shift register.
  - o_px/o_py remain undelayed, so a pattern generator with SYNC_DELAY latency lines up with the syncs.
  - Delay stages reset to the inactive values above.
  - SYNC_DELAY = 0 is legal and means a pass-through.
- Undefined: zero delay, SYNC_DELAY is ignored, and no delay registers are built.

## Structure
- Package vga_timing_pkg:
  - 640x480@60 timing constants (the defaults above).
  - COORD_W.
  - A timing-record typedef (active/fp/sync/bp) for horizontal and vertical.
- Sub-module vga_delay_line: WIDTH/DEPTH-parametrised synchronous shift register with per-bit reset value. It is instantiated only under VGA_TIMING_DELAY_EN.

## Test plan
- Default parameters, reset for 3 cycles, release:
  - first edge -> px=0, py=0, activeArea=1, frameStart=1.
  - px=639 -> activeArea=1; px=640 -> activeArea=0.
- Default line:
  - o_hs=0 exactly for px 656..751 (96 cycles), 1 elsewhere.
  - lineStart pulses every 800 cycles.
- Default frame:
  - o_vs=0 for py 490..491 (1600 cycles).
  - frameStart pulses every 420 000 cycles.
  - (799,524) -> (0,0).
- Reset asserted at (300,200) for 1 cycle:
  - next edge -> all reset values.
  - first edge after release -> (0,0) with frameStart=1.
- Small timing, H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=1:
  - hs=1 only at px 10..11.
  - vs=1 only on py 5.
  - line 14 cycles, frame 98 cycles.
- VGA_TIMING_DELAY_EN, SYNC_DELAY=2:
  - activeArea rises 2 cycles after px=0.
  - hs falls when px=658.
  - frameStart is seen at px=2, py=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants, coordinate width and timing-record helpers.
// Shared by the timing generator and its consumers.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } timing_t;

  localparam int COORD_W = 10;

  localparam timing_t VGA640_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam timing_t VGA640_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

  function automatic int unsigned timing_total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // First coordinate inside the sync pulse; the pulse ends sync cycles later.
  function automatic int unsigned timing_sync_start(timing_t t);
    return t.active + t.fp;
  endfunction

  function automatic int unsigned timing_sync_end(timing_t t);
    return t.active + t.fp + t.sync;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH synchronous shift register with per-bit reset value; DEPTH=0 is a wire.
// Latency DEPTH cycles, no backpressure.
module vga_delay_line #(
  parameter int              WIDTH   = 1,
  parameter int              DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_dat = i_dat;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
          end
        end else begin
          stage_q[0] <= i_dat;
          for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign o_dat = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/coordinate generator, registered outputs, 0-cycle latency, free-running.
// VGA_TIMING_DELAY_EN: syncs/activeArea/strobes delayed SYNC_DELAY cycles behind o_px/o_py.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int COORD_W    = vga_timing_pkg::COORD_W,
  parameter int SYNC_DELAY = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic               o_hs,
  output logic               o_vs,
  output logic               o_activeArea,
  output logic [COORD_W-1:0] o_px,
  output logic [COORD_W-1:0] o_py,
  output logic               o_lineStart,
  output logic               o_frameStart
);

  localparam timing_t H_TIM = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_t V_TIM = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

  localparam int unsigned H_TOTAL = timing_total(H_TIM);
  localparam int unsigned V_TOTAL = timing_total(V_TIM);

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  // One extra bit so a boundary equal to 2^COORD_W does not wrap to zero.
  localparam logic [COORD_W:0] H_ACT_END  = (COORD_W+1)'(H_TIM.active);
  localparam logic [COORD_W:0] H_SYNC_BEG = (COORD_W+1)'(timing_sync_start(H_TIM));
  localparam logic [COORD_W:0] H_SYNC_END = (COORD_W+1)'(timing_sync_end(H_TIM));
  localparam logic [COORD_W:0] V_ACT_END  = (COORD_W+1)'(V_TIM.active);
  localparam logic [COORD_W:0] V_SYNC_BEG = (COORD_W+1)'(timing_sync_start(V_TIM));
  localparam logic [COORD_W:0] V_SYNC_END = (COORD_W+1)'(timing_sync_end(V_TIM));

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic [COORD_W-1:0] px_q, py_q;
  logic [COORD_W-1:0] px_d, py_d;
  logic [COORD_W:0]   px_ext, py_ext;
  logic               hs_d, vs_d, act_d, ls_d, fs_d;

  logic [COORD_W-1:0] px_out_q, py_out_q;
  logic               hs_q, vs_q, act_q, ls_q, fs_q;

  always_comb begin
    px_d = px_q + COORD_W'(1);
    py_d = py_q;
    if (px_q == H_LAST) begin
      px_d = '0;
      py_d = (py_q == V_LAST) ? '0 : py_q + COORD_W'(1);
    end
  end

  // Outputs decode the next position so they land on the same edge as the coordinates.
  always_comb begin
    px_ext = {1'b0, px_d};
    py_ext = {1'b0, py_d};
    hs_d   = (px_ext >= H_SYNC_BEG && px_ext < H_SYNC_END) ? HS_ON : ~HS_ON;
    vs_d   = (py_ext >= V_SYNC_BEG && py_ext < V_SYNC_END) ? VS_ON : ~VS_ON;
    act_d  = (px_ext < H_ACT_END) && (py_ext < V_ACT_END);
    ls_d   = (px_d == '0);
    fs_d   = (px_d == '0) && (py_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      px_q     <= H_LAST;
      py_q     <= V_LAST;
      px_out_q <= '0;
      py_out_q <= '0;
      hs_q     <= ~HS_ON;
      vs_q     <= ~VS_ON;
      act_q    <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      px_q     <= px_d;
      py_q     <= py_d;
      px_out_q <= px_d;
      py_out_q <= py_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      act_q    <= act_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
    end
  end

  assign o_px = px_out_q;
  assign o_py = py_out_q;

`ifdef VGA_TIMING_DELAY_EN
  logic [4:0] dly_dat;

  vga_delay_line #(
    .WIDTH   (5),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL ({~HS_ON, ~VS_ON, 3'b000})
  ) u_sync_dly (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_dat   ({hs_q, vs_q, act_q, ls_q, fs_q}),
    .o_dat   (dly_dat)
  );

  assign {o_hs, o_vs, o_activeArea, o_lineStart, o_frameStart} = dly_dat;
`else
  generate
    if (SYNC_DELAY < 0) begin : g_sync_delay_unused
    end
  endgenerate

  assign o_hs         = hs_q;
  assign o_vs         = vs_q;
  assign o_activeArea = act_q;
  assign o_lineStart  = ls_q;
  assign o_frameStart = fs_q;
`endif

endmodule
